// File: rtl/ether_tx_dibit.sv
// RMII-style transmit serializer: bytes in, LSB-first dibits out, with preamble/SFD,
// interframe gap and underrun abort. Define ETHER_TX_PREAMBLE_EN to insert preamble+SFD.
module ether_tx_dibit #(
  parameter int IFG_CYCLES = 48
`ifdef ETHER_TX_PREAMBLE_EN
  , parameter int PREAMBLE_BYTES = 7
`endif
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       axiiv,
  input  logic [7:0] axiid,
  input  logic       axiil,
  output logic       axiir,
  output logic       axiov,
  output logic [1:0] axiod,
  output logic       underrun
);

  localparam int CNT_W = 16;
  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_DATA  = 3'd2;
  localparam logic [2:0] S_DRAIN = 3'd3;
  localparam logic [2:0] S_IFG   = 3'd4;
`ifdef ETHER_TX_PREAMBLE_EN
  localparam logic [2:0] S_PRE   = 3'd1;
  localparam logic [CNT_W-1:0] PRE_LAST = CNT_W'(PREAMBLE_BYTES * 4 + 3);
  localparam logic [CNT_W-1:0] PRE_SFD  = CNT_W'(PREAMBLE_BYTES * 4 + 2);
`endif
  localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(3);
  localparam logic [CNT_W-1:0] IFG_LAST  = CNT_W'(IFG_CYCLES - 1);

  logic [2:0]       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [7:0]       r_sh;
  logic             r_sh_last;
  logic [7:0]       r_buf;
  logic             r_buf_last;
  logic             r_buf_valid;
  logic             r_axiir;
  logic             r_axiov;
  logic [1:0]       r_axiod;
  logic             r_underrun;

  logic [2:0]       w_state;
  logic [CNT_W-1:0] w_cnt;
  logic [7:0]       w_sh;
  logic             w_sh_last;
  logic [7:0]       w_buf;
  logic             w_buf_last;
  logic             w_buf_valid;
  logic             w_axiir;
  logic             w_axiov;
  logic [1:0]       w_axiod;
  logic             w_underrun;
  logic             w_xfer;
  logic             w_store;
  logic             w_start;
  logic [1:0]       w_dsel;
  logic [1:0]       w_dibit;

  assign w_xfer = axiiv && r_axiir;
  assign w_dsel = r_cnt[1:0] + 2'd1;

  always_comb begin
    w_dibit = r_sh[1:0];
    case (w_dsel)
      2'd1:    w_dibit = r_sh[3:2];
      2'd2:    w_dibit = r_sh[5:4];
      2'd3:    w_dibit = r_sh[7:6];
      default: w_dibit = r_sh[1:0];
    endcase
  end

  always_comb begin
    w_state     = r_state;
    w_cnt       = r_cnt;
    w_sh        = r_sh;
    w_sh_last   = r_sh_last;
    w_buf       = r_buf;
    w_buf_last  = r_buf_last;
    w_buf_valid = r_buf_valid;
    w_axiov     = 1'b0;
    w_axiod     = 2'b00;
    w_underrun  = 1'b0;
    w_start     = 1'b0;
    w_store     = w_xfer;

    case (r_state)
      S_IDLE: w_start = r_buf_valid;
`ifdef ETHER_TX_PREAMBLE_EN
      S_PRE: begin
        w_axiov = 1'b1;
        if (r_cnt == PRE_LAST) begin
          w_state = S_DATA;
          w_cnt   = '0;
          w_axiod = r_sh[1:0];
        end else begin
          w_cnt   = r_cnt + CNT_W'(1);
          w_axiod = (r_cnt == PRE_SFD) ? 2'b11 : 2'b01;
        end
      end
`endif
      S_DATA: begin
        if (r_cnt != DATA_LAST) begin
          w_axiov = 1'b1;
          w_cnt   = r_cnt + CNT_W'(1);
          w_axiod = w_dibit;
        end else if (r_sh_last) begin
          w_state = S_IFG;
          w_cnt   = '0;
        end else if (r_buf_valid) begin
          w_axiov     = 1'b1;
          w_cnt       = '0;
          w_sh        = r_buf;
          w_sh_last   = r_buf_last;
          w_buf_valid = 1'b0;
          w_axiod     = r_buf[1:0];
        end else begin
          // A byte arriving on this very edge is too late; if it closes the
          // frame there is nothing left to drain.
          w_underrun  = 1'b1;
          w_store     = 1'b0;
          w_buf_valid = 1'b0;
          w_cnt       = '0;
          w_state     = (w_xfer && axiil) ? S_IFG : S_DRAIN;
        end
      end
      S_DRAIN: begin
        w_store = 1'b0;
        if (w_xfer && axiil) begin
          w_state = S_IFG;
          w_cnt   = '0;
        end
      end
      S_IFG: begin
        if (r_cnt == IFG_LAST) begin
          w_state = S_IDLE;
          w_start = r_buf_valid;
        end else begin
          w_cnt = r_cnt + CNT_W'(1);
        end
      end
      default: w_state = S_IDLE;
    endcase

    // Leaving the gap with a byte already buffered starts the frame without an extra idle cycle.
    if (w_start) begin
      w_sh        = r_buf;
      w_sh_last   = r_buf_last;
      w_buf_valid = 1'b0;
      w_axiov     = 1'b1;
      w_cnt       = '0;
`ifdef ETHER_TX_PREAMBLE_EN
      w_state     = S_PRE;
      w_axiod     = 2'b01;
`else
      w_state     = S_DATA;
      w_axiod     = r_buf[1:0];
`endif
    end

    if (w_store) begin
      w_buf       = axiid;
      w_buf_last  = axiil;
      w_buf_valid = 1'b1;
    end

    w_axiir = (w_state == S_DRAIN) ? 1'b1 : !w_buf_valid;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_sh        <= '0;
      r_sh_last   <= 1'b0;
      r_buf       <= '0;
      r_buf_last  <= 1'b0;
      r_buf_valid <= 1'b0;
      r_axiir     <= 1'b0;
      r_axiov     <= 1'b0;
      r_axiod     <= 2'b00;
      r_underrun  <= 1'b0;
    end else begin
      r_state     <= w_state;
      r_cnt       <= w_cnt;
      r_sh        <= w_sh;
      r_sh_last   <= w_sh_last;
      r_buf       <= w_buf;
      r_buf_last  <= w_buf_last;
      r_buf_valid <= w_buf_valid;
      r_axiir     <= w_axiir;
      r_axiov     <= w_axiov;
      r_axiod     <= w_axiod;
      r_underrun  <= w_underrun;
    end
  end

  assign axiir    = r_axiir;
  assign axiov    = r_axiov;
  assign axiod    = r_axiod;
  assign underrun = r_underrun;

endmodule

// File: tb/tb_ether_tx_dibit.sv
// Directed bench for ether_tx_dibit: cycle-exact vector table for a frame plus a
// back-to-back frame, then hand-written underrun and mid-frame reset sequences.
module tb_ether_tx_dibit;

`ifdef ETHER_TX_PREAMBLE_EN
  localparam int D = 32;
`else
  localparam int D = 0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       axiiv;
  logic [7:0] axiid;
  logic       axiil;
  logic       axiir;
  logic       axiov;
  logic [1:0] axiod;
  logic       underrun;

  ether_tx_dibit dut (
    .clk      (clk),
    .rst      (rst),
    .axiiv    (axiiv),
    .axiid    (axiid),
    .axiil    (axiil),
    .axiir    (axiir),
    .axiov    (axiov),
    .axiod    (axiod),
    .underrun (underrun)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       iv;
    logic [7:0] id;
    logic       il;
    logic [7:0] exp;
  } vec_t;

  vec_t tbl [0:199];

  logic [1:0] da [12] = '{2'b01, 2'b01, 2'b01, 2'b01,
                          2'b00, 2'b11, 2'b00, 2'b01,
                          2'b10, 2'b00, 2'b01, 2'b00};
  logic [1:0] db [4]  = '{2'b01, 2'b01, 2'b01, 2'b11};

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic xfer;
  logic       ov_log [0:2047];
  logic [1:0] od_log [0:2047];
  logic       ur_log [0:2047];
  logic       ir_log [0:2047];

  function automatic logic [7:0] pk(input logic ir, input logic ov, input logic [1:0] od, input logic ur);
    return {3'b000, ir, ov, od, ur};
  endfunction

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %02h expected %02h", name, act, exp);
    end
  endtask

  task automatic tick();
    logic pre_ir;
    pre_ir = axiir;
    @(posedge clk);
    #1;
    cyc++;
    xfer = axiiv && pre_ir && rst;
    ov_log[cyc] = axiov;
    od_log[cyc] = axiod;
    ur_log[cyc] = underrun;
    ir_log[cyc] = axiir;
    if (xfer) $display("cyc %0d: byte %02h last=%0b accepted", cyc, axiid, axiil);
  endtask

  task automatic send_byte(input logic [7:0] d, input logic l, output int at);
    int n;
    n = 0;
    axiiv = 1'b1;
    axiid = d;
    axiil = l;
    do begin
      tick();
      n++;
    end while (!xfer && n < 200);
    if (!xfer) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: byte %02h not accepted within %0d cycles", d, n);
    end
    at = cyc;
    axiiv = 1'b0;
  endtask

  initial begin
    int nr, b, n0, m, n2, ur_sum, ov_sum;
    logic e_ir, e_ov;
    logic [1:0] e_od;

    // Frame A (55 4C 12*) back to back, then one-byte frame D5* offered during the gap.
    nr = 2 * D + 66;
    b  = D + 61;
    for (int k = 0; k < nr; k++) begin
      tbl[k].iv = 1'b0;
      tbl[k].id = 8'h00;
      tbl[k].il = 1'b0;
      if (k == 0) begin
        tbl[k].iv = 1'b1; tbl[k].id = 8'h55;
      end else if (k <= 2) begin
        tbl[k].iv = 1'b1; tbl[k].id = 8'h4C;
      end else if (k <= D + 6) begin
        tbl[k].iv = 1'b1; tbl[k].id = 8'h12; tbl[k].il = 1'b1;
      end else if (k == D + 20) begin
        tbl[k].iv = 1'b1; tbl[k].id = 8'hD5; tbl[k].il = 1'b1;
      end
      if (k == 0)           e_ir = 1'b0;
      else if (k == 1)      e_ir = 1'b1;
      else if (k <= D + 4)  e_ir = 1'b0;
      else if (k == D + 5)  e_ir = 1'b1;
      else if (k <= D + 8)  e_ir = 1'b0;
      else if (k <= D + 19) e_ir = 1'b1;
      else if (k <= D + 60) e_ir = 1'b0;
      else                  e_ir = 1'b1;
      e_ov = 1'b0;
      e_od = 2'b00;
      if (k >= 1 && k <= D) begin
        e_ov = 1'b1; e_od = (k == D) ? 2'b11 : 2'b01;
      end else if (k >= D + 1 && k <= D + 12) begin
        e_ov = 1'b1; e_od = da[k - D - 1];
      end else if (k >= b && k < b + D) begin
        e_ov = 1'b1; e_od = (k == b + D - 1) ? 2'b11 : 2'b01;
      end else if (k >= b + D && k < b + D + 4) begin
        e_ov = 1'b1; e_od = db[k - b - D];
      end
      tbl[k].exp = pk(e_ir, e_ov, e_od, 1'b0);
    end

    // Reset held with valid asserted.
    rst = 1'b0; axiiv = 1'b1; axiid = 8'hFF; axiil = 1'b0;
    tick();
    check("reset_c1", pk(axiir, axiov, axiod, underrun), 8'h00);
    tick();
    check("reset_c2", pk(axiir, axiov, axiod, underrun), 8'h00);
    rst = 1'b1; axiiv = 1'b0;
    repeat (4) tick();

    for (int k = 0; k < nr; k++) begin
      axiiv = tbl[k].iv;
      axiid = tbl[k].id;
      axiil = tbl[k].il;
      tick();
      check($sformatf("vec%0d", k), pk(axiir, axiov, axiod, underrun), tbl[k].exp);
    end
    axiiv = 1'b0;
    repeat (50) tick();

    // Underrun after a single non-last byte, then the tail is drained silently.
    send_byte(8'hD5, 1'b0, n0);
    repeat (D + 6) tick();
    for (int j = 0; j < 4; j++)
      check($sformatf("ur_dibit%0d", j), {5'b0, ov_log[n0 + D + 1 + j], od_log[n0 + D + 1 + j]},
            {5'b0, 1'b1, db[j]});
    ur_sum = 0;
    for (int c = n0; c < n0 + D + 5; c++) ur_sum += int'(ur_log[c]);
    check("ur_early", 8'(ur_sum), 8'd0);
    check("ur_pulse", pk(ir_log[n0 + D + 5], ov_log[n0 + D + 5], od_log[n0 + D + 5], ur_log[n0 + D + 5]),
          pk(1'b1, 1'b0, 2'b00, 1'b1));
    check("ur_after", {6'b0, ov_log[n0 + D + 6], ur_log[n0 + D + 6]}, 8'd0);
    axiiv = 1'b1; axiid = 8'hAA; axiil = 1'b0;
    tick();
    check("drain_aa", {6'b0, xfer, axiov}, 8'h02);
    axiid = 8'h00; axiil = 1'b1;
    tick();
    check("drain_00", {6'b0, xfer, axiov}, 8'h02);
    m = cyc;
    axiid = 8'h12; axiil = 1'b1;
    tick();
    check("ifg_buffered", {6'b0, xfer, axiir}, 8'h02);
    axiiv = 1'b0;
    while (cyc < m + 48) tick();
    ov_sum = 0;
    for (int c = m; c <= m + 47; c++) ov_sum += int'(ov_log[c]);
    check("ifg_quiet", 8'(ov_sum), 8'd0);
    check("ifg_end", {5'b0, ov_log[m + 48], od_log[m + 48]},
          {5'b0, 1'b1, (D > 0) ? 2'b01 : 2'b10});
    repeat (100) tick();

    // Reset during the second data byte.
    send_byte(8'h55, 1'b0, n0);
    send_byte(8'h4C, 1'b0, n2);
    axiiv = 1'b1; axiid = 8'h12; axiil = 1'b1;
    while (cyc < n0 + D + 6) tick();
    check("mid_b1d0", {5'b0, ov_log[n0 + D + 5], od_log[n0 + D + 5]}, 8'b0000_0100);
    check("mid_b1d1", {5'b0, ov_log[n0 + D + 6], od_log[n0 + D + 6]}, 8'b0000_0111);
    rst = 1'b0; axiiv = 1'b0;
    tick();
    check("mid_rst", pk(axiir, axiov, axiod, underrun), 8'h00);
    rst = 1'b1;
    tick();
    check("mid_release", pk(axiir, axiov, axiod, underrun), pk(1'b1, 1'b0, 2'b00, 1'b0));
    send_byte(8'hD5, 1'b1, n2);
    repeat (D + 6) tick();
    check("post_first", {5'b0, ov_log[n2 + 1], od_log[n2 + 1]}, 8'b0000_0101);
    for (int j = 0; j < 4; j++)
      check($sformatf("post_dibit%0d", j), {5'b0, ov_log[n2 + D + 1 + j], od_log[n2 + D + 1 + j]},
            {5'b0, 1'b1, db[j]});
    check("post_end", {6'b0, ov_log[n2 + D + 5], ur_log[n2 + D + 5]}, 8'd0);
    ur_sum = 0;
    for (int c = n0; c <= cyc; c++) ur_sum += int'(ur_log[c]);
    check("mid_no_underrun", 8'(ur_sum), 8'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
